instr_issuer: RTL and testbench

- Instruction sequencer that drives the processor control FSM's request side: `w`, `func`, `rx`, `ry` and the immediate data bus `din`.
- Fetches 16-bit instruction words from a synchronous program ROM.
- Presents each instruction with `w` held high until the control FSM returns a `done` pulse, then advances.
- Sits between program ROM and control FSM; stops on HALT, illegal opcode or handshake timeout.

---
 rtl/instr_issuer.sv | 129 ++++++++++++
 tb/tb_instr_issuer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issuer.sv
// Instruction sequencer: fetches 16-bit words from a synchronous program ROM and
// hands each instruction to the control FSM with a w/done handshake.
module instr_issuer #(
  parameter int PC_W    = 5,
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              run,
  input  logic [PC_W-1:0]   start_pc,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [15:0]       rom_data,
  output logic              w,
  output logic [2:0]        func,
  output logic [3:0]        rx,
  output logic [3:0]        ry,
  output logic [15:0]       din,
  input  logic              done,
  output logic              busy,
  output logic              halted,
  output logic              error,
  output logic [PC_W-1:0]   pc,
  output logic [CNT_W-1:0]  instr_count
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, IMM_WAIT, IMM_CAP, ISSUE, HALT, ERR
  } state_t;

  state_t          state;
  logic [TO_W-1:0] to_cnt;
  logic [PC_W-1:0] pc_next;
  logic            unused_bits;

  assign pc_next     = pc + PC_W'(1);
  assign unused_bits = &rom_data[4:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      to_cnt      <= '0;
      rom_addr    <= '0;
      w           <= 1'b0;
      func        <= '0;
      rx          <= '0;
      ry          <= '0;
      din         <= '0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      error       <= 1'b0;
      pc          <= '0;
      instr_count <= '0;
    end else begin
      case (state)
        IDLE, HALT, ERR: begin
          if (run) begin
            pc          <= start_pc;
            rom_addr    <= start_pc;
            error       <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
            busy        <= 1'b1;
            state       <= FETCH;
          end
        end
        FETCH: state <= DECODE;
        DECODE: begin
          func     <= rom_data[15:13];
          rx       <= rom_data[12:9];
          ry       <= rom_data[8:5];
          din      <= '0;
          pc       <= pc_next;
          rom_addr <= pc_next;
          case (rom_data[15:13])
            3'b111: begin
              halted <= 1'b1;
              busy   <= 1'b0;
              state  <= HALT;
            end
            3'b100, 3'b101, 3'b110: begin
              error <= 1'b1;
              busy  <= 1'b0;
              state <= ERR;
            end
            3'b000: state <= IMM_WAIT;
            default: begin
              w      <= 1'b1;
              to_cnt <= '0;
              state  <= ISSUE;
            end
          endcase
        end
        IMM_WAIT: state <= IMM_CAP;
        IMM_CAP: begin
          din      <= rom_data;
          pc       <= pc_next;
          rom_addr <= pc_next;
          w        <= 1'b1;
          to_cnt   <= '0;
          state    <= ISSUE;
        end
        ISSUE: begin
          // done takes priority over a timeout expiring in the same cycle
          if (done) begin
            w           <= 1'b0;
            din         <= '0;
            instr_count <= instr_count + CNT_W'(1);
            to_cnt      <= '0;
            state       <= FETCH;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            w      <= 1'b0;
            din    <= '0;
            error  <= 1'b1;
            busy   <= 1'b0;
            to_cnt <= '0;
            state  <= ERR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_issuer.sv
// Self-checking bench for instr_issuer: ROM model, randomized control-FSM responder
// and a program-walking reference model of the expected issue stream.
module tb_instr_issuer;

  localparam int PC_W    = 5;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;
  localparam int DEPTH   = 1 << PC_W;

  logic              clk;
  logic              resetn;
  logic              run;
  logic [PC_W-1:0]   start_pc;
  logic [PC_W-1:0]   rom_addr;
  logic [15:0]       rom_data;
  logic              w;
  logic [2:0]        func;
  logic [3:0]        rx;
  logic [3:0]        ry;
  logic [15:0]       din;
  logic              done;
  logic              busy;
  logic              halted;
  logic              error;
  logic [PC_W-1:0]   pc;
  logic [CNT_W-1:0]  instr_count;

  instr_issuer #(.PC_W(PC_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .run(run), .start_pc(start_pc),
    .rom_addr(rom_addr), .rom_data(rom_data), .w(w), .func(func),
    .rx(rx), .ry(ry), .din(din), .done(done), .busy(busy),
    .halted(halted), .error(error), .pc(pc), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] rom [DEPTH];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed {
    logic [2:0]      f;
    logic [3:0]      rx;
    logic [3:0]      ry;
    logic [15:0]     imm;
    logic [PC_W-1:0] pc_after;
  } instr_t;

  instr_t          exp_q[$];
  logic [PC_W-1:0] exp_pc;
  bit              exp_halt;
  bit              exp_err;

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) rom[i] = 16'hE000;
  endtask

  // Walk the program the way the ISA describes it and list what should be issued
  task automatic model_program(input int start);
    int          p;
    logic [15:0] word;
    logic [15:0] imm;
    p = start;
    exp_q.delete();
    exp_halt = 0;
    exp_err  = 0;
    for (int n = 0; n < 40; n++) begin
      word = rom[p];
      p = (p + 1) % DEPTH;
      if (word[15:13] == 3'b111) begin exp_halt = 1; break; end
      if (word[15:13] >= 3'b100) begin exp_err = 1; break; end
      imm = 16'h0;
      if (word[15:13] == 3'b000) begin
        imm = rom[p];
        p = (p + 1) % DEPTH;
      end
      exp_q.push_back('{f: word[15:13], rx: word[12:9], ry: word[8:5], imm: imm,
                        pc_after: PC_W'(p)});
    end
    exp_pc = PC_W'(p);
  endtask

  // fixed_delay < 0 picks a random done delay per instruction
  task automatic apply_stimulus(input int start, input int fixed_delay,
                                input bit spurious, input bit run_while_busy);
    int guard;
    int d;
    model_program(start);
    @(negedge clk);
    start_pc = PC_W'(start);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    start_pc = PC_W'(start + 7);
    check_output("busy_set", busy, 1);
    foreach (exp_q[i]) begin
      guard = 0;
      while (!w && guard < 100) begin
        done = spurious && ($urandom_range(0, 3) == 0);
        @(negedge clk);
        guard++;
      end
      done = 1'b0;
      if (!w) begin
        check_output("w_rise", w, 1);
        return;
      end
      d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 5);
      for (int k = 0; k <= d; k++) begin
        check_output("w_hold", w, 1);
        check_output("func", func, exp_q[i].f);
        check_output("rx", rx, exp_q[i].rx);
        check_output("ry", ry, exp_q[i].ry);
        check_output("din", din, exp_q[i].imm);
        check_output("pc_issue", pc, exp_q[i].pc_after);
        if (run_while_busy && i == 0 && k == 0) run = 1'b1;
        if (k == d) done = 1'b1;
        @(negedge clk);
        run  = 1'b0;
        done = 1'b0;
      end
      check_output("w_fall", w, 0);
      check_output("count_step", instr_count, i + 1);
    end
    guard = 0;
    while (busy && guard < 100) begin
      check_output("w_quiet", w, 0);
      @(negedge clk);
      guard++;
    end
    check_output("busy_clear", busy, 0);
    check_output("halted", halted, exp_halt);
    check_output("error", error, exp_err);
    check_output("pc_end", pc, exp_pc);
    check_output("count_end", instr_count, exp_q.size());
    check_output("w_end", w, 0);
  endtask

  initial begin
    int guard;
    int hi;
    int p;
    int n;
    int start;
    logic [2:0] f;

    resetn   = 1'b0;
    run      = 1'b0;
    done     = 1'b0;
    start_pc = '0;
    clear_rom();
    #12;
    check_output("rst_w", w, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_pc", pc, 0);
    check_output("rst_addr", rom_addr, 0);
    check_output("rst_din", din, 0);
    check_output("rst_flags", {halted, error}, 0);
    check_output("rst_count", instr_count, 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] load immediate then halt");
    clear_rom();
    rom[0] = 16'h0200; rom[1] = 16'h0005; rom[2] = 16'hE000;
    apply_stimulus(0, 2, 0, 0);

    $display("[TB] add held five cycles");
    clear_rom();
    rom[0] = 16'h4420; rom[1] = 16'hE000;
    apply_stimulus(0, 5, 0, 0);

    $display("[TB] illegal opcode then recovery");
    clear_rom();
    rom[0] = 16'h8000;
    apply_stimulus(0, 0, 0, 0);
    rom[4] = 16'h2220; rom[5] = 16'hE000;
    apply_stimulus(4, 1, 0, 0);

    $display("[TB] handshake timeout");
    clear_rom();
    rom[0] = 16'h2220;
    @(negedge clk);
    start_pc = '0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    guard = 0;
    while (!w && guard < 20) begin @(negedge clk); guard++; end
    hi = 0;
    while (w && hi < 40) begin @(negedge clk); hi++; end
    check_output("to_width", hi, TIMEOUT);
    check_output("to_error", error, 1);
    check_output("to_halted", halted, 0);
    check_output("to_busy", busy, 0);
    check_output("to_count", instr_count, 0);

    $display("[TB] done on last timeout cycle");
    clear_rom();
    rom[0] = 16'h2220; rom[1] = 16'h6A40; rom[2] = 16'hE000;
    apply_stimulus(0, TIMEOUT - 1, 0, 0);

    $display("[TB] pc wrap");
    clear_rom();
    rom[31] = 16'h2220; rom[0] = 16'hE000;
    apply_stimulus(31, 0, 0, 0);

    $display("[TB] run while busy");
    clear_rom();
    rom[8] = 16'h4420; rom[9] = 16'h0600; rom[10] = 16'hBEEF; rom[11] = 16'hE000;
    apply_stimulus(8, -1, 1, 1);

    $display("[TB] reset in third issue cycle");
    clear_rom();
    rom[0] = 16'h2220;
    @(negedge clk);
    start_pc = '0;
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    guard = 0;
    while (!w && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    @(negedge clk);
    check_output("pre_rst_w", w, 1);
    resetn = 1'b0;
    #1;
    check_output("arst_w", w, 0);
    check_output("arst_busy", busy, 0);
    check_output("arst_pc", pc, 0);
    check_output("arst_count", instr_count, 0);
    check_output("arst_flags", {halted, error}, 0);
    @(negedge clk);
    resetn = 1'b1;

    $display("[TB] random programs");
    for (int t = 0; t < 20; t++) begin
      clear_rom();
      start = $urandom_range(0, DEPTH - 1);
      p = start;
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        f = 3'($urandom_range(0, 3));
        rom[p] = {f, 13'($urandom)};
        p = (p + 1) % DEPTH;
        if (f == 3'b000) begin
          rom[p] = 16'($urandom);
          p = (p + 1) % DEPTH;
        end
      end
      if ($urandom_range(0, 3) == 0) rom[p] = {3'($urandom_range(4, 6)), 13'($urandom)};
      else                           rom[p] = {3'b111, 13'($urandom)};
      apply_stimulus(start, -1, 1, (t % 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
